// File: rtl/stack_queue_buffer_if.sv
// Push/pop bus between a producer/consumer (master) and the buffer (slave).
interface stack_queue_buffer_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);
    logic              mode;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] D_in;
    logic [DATA_W-1:0] Data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              mode_act;
    logic              overflow;
    logic              underflow;

    modport master (
        output mode, push, pop, D_in,
        input  Data_out, valid_out, full, empty, count, mode_act, overflow, underflow
    );

    modport slave (
        input  mode, push, pop, D_in,
        output Data_out, valid_out, full, empty, count, mode_act, overflow, underflow
    );
endinterface

// File: rtl/stack_queue_buffer.sv
// Parametrised storage buffer with run-time FIFO/LIFO ordering, occupancy status
// and overflow/underflow pulses. Single clock, synchronous active-high reset.
module stack_queue_buffer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                reset,
    stack_queue_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              mode_act_q, mode_act_d;

    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              pop_ok;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  cnt_idx;

    // Occupancy status and request acceptance.
    always_comb begin
        full_w  = (count_q == CNT_W'(DEPTH));
        empty_w = (count_q == '0);
        pop_ok  = bus.pop && !empty_w;
        // A full buffer still takes a push when a pop frees a slot on the same edge.
        push_ok = bus.push && (!full_w || pop_ok);
        cnt_idx = count_q[PTR_W-1:0];
        top_idx = cnt_idx - PTR_W'(1);
    end

    // Next-state: storage, pointers, occupancy, read data and pulses.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        data_out_d  = data_out_q;
        valid_d     = pop_ok;
        overflow_d  = bus.push && !push_ok;
        underflow_d = bus.pop && !pop_ok;
        mode_act_d  = mode_act_q;

        if (!mode_act_q) begin
            // FIFO: independent circular pointers, natural wrap as DEPTH is a power of two.
            if (pop_ok) begin
                data_out_d = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok) begin
                mem_d[wr_ptr_q] = bus.D_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            // LIFO: top of stack is mem[count-1]; simultaneous push+pop replaces the top.
            if (pop_ok) begin
                data_out_d = mem_q[top_idx];
            end
            if (push_ok) begin
                if (pop_ok) begin
                    mem_d[top_idx] = bus.D_in;
                end else begin
                    mem_d[cnt_idx] = bus.D_in;
                end
            end
        end

        // Ordering may only change while drained and nothing is being written.
        if (empty_w && !push_ok) begin
            mode_act_d = bus.mode;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mode_act_q  <= bus.mode;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mode_act_q  <= mode_act_d;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.Data_out  = data_out_q;
        bus.valid_out = valid_q;
        bus.full      = full_w;
        bus.empty     = empty_w;
        bus.count     = count_q;
        bus.mode_act  = mode_act_q;
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end
endmodule

// File: tb/tb_stack_queue_buffer.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs and
// every popped word; a negedge monitor consumes the predictions and compares.
module tb_stack_queue_buffer;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stack_queue_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    stack_queue_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [CNT_W-1:0]  cnt;
        logic              full;
        logic              empty;
        logic              mode_act;
        logic              valid;
        logic              ovf;
        logic              unf;
        logic [DATA_W-1:0] dout;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] pop_q[$];

    // Reference model state.
    logic [DATA_W-1:0] model[$];
    logic              m_mode;
    logic [DATA_W-1:0] m_last;

    int vectors     = 0;
    int miscompares = 0;
    logic mode_in   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic md, input logic ps,
                                input logic pp, input logic [DATA_W-1:0] d);
        exp_t e;
        bit   pk, pa;
        int   size_before;
        e = '0;
        if (rst) begin
            model.delete();
            m_mode = md;
            m_last = '0;
        end else begin
            size_before = model.size();
            pk = pp && (size_before > 0);
            pa = ps && ((size_before < int'(DEPTH)) || pk);
            e.ovf   = ps && !pa;
            e.unf   = pp && !pk;
            e.valid = pk;
            if (pk) begin
                m_last = m_mode ? model.pop_back() : model.pop_front();
                pop_q.push_back(m_last);
            end
            if (pa) model.push_back(d);
            if (size_before == 0 && !pa) m_mode = md;
        end
        e.cnt      = CNT_W'(model.size());
        e.full     = (model.size() == int'(DEPTH));
        e.empty    = (model.size() == 0);
        e.mode_act = m_mode;
        e.dout     = m_last;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic md, input logic ps, input logic pp,
                        input logic [DATA_W-1:0] d);
        reset     = rst;
        bus.mode  = md;
        bus.push  = ps;
        bus.pop   = pp;
        bus.D_in  = d;
        @(posedge clk);
        model_update(rst, md, ps, pp, d);
        @(negedge clk);
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        step(1'b0, mode_in, 1'b1, 1'b0, d);
    endtask

    task automatic do_pop();
        step(1'b0, mode_in, 1'b0, 1'b1, '0);
    endtask

    task automatic do_idle();
        step(1'b0, mode_in, 1'b0, 1'b0, '0);
    endtask

    // Monitor: one prediction per clock, plus popped-word check whenever valid_out is seen.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("count",     32'(bus.count),     32'(e.cnt));
            chk("full",      32'(bus.full),      32'(e.full));
            chk("empty",     32'(bus.empty),     32'(e.empty));
            chk("mode_act",  32'(bus.mode_act),  32'(e.mode_act));
            chk("valid_out", 32'(bus.valid_out), 32'(e.valid));
            chk("overflow",  32'(bus.overflow),  32'(e.ovf));
            chk("underflow", 32'(bus.underflow), 32'(e.unf));
            chk("Data_out",  32'(bus.Data_out),  32'(e.dout));
            if (bus.valid_out === 1'b1) begin
                if (pop_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_data: got valid_out with %0h, expected no pop",
                             bus.Data_out);
                end else begin
                    chk("pop_data", 32'(bus.Data_out), 32'(pop_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.mode = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.D_in = '0;
        reset    = 1'b1;

        // Reset then idle.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        do_idle();
        do_idle();

        // FIFO fill, overflow, drain, underflow.
        for (int i = 1; i <= 8; i++) do_push(DATA_W'(i));
        do_push(4'd9);
        for (int i = 0; i < 8; i++) do_pop();
        do_pop();

        // LIFO order.
        mode_in = 1'b1;
        do_idle();
        for (int i = 1; i <= 5; i++) do_push(DATA_W'(i));
        for (int i = 0; i < 3; i++) do_pop();
        do_push(4'd6);
        for (int i = 0; i < 3; i++) do_pop();

        // FIFO pointer wrap with simultaneous push+pop.
        mode_in = 1'b0;
        do_idle();
        for (int i = 1; i <= 6; i++) do_push(DATA_W'(i));
        for (int i = 0; i < 4; i++) do_pop();
        for (int i = 7; i <= 10; i++) do_push(DATA_W'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd11);
        for (int i = 0; i < 6; i++) do_pop();

        // LIFO simultaneous push+pop.
        mode_in = 1'b1;
        do_idle();
        for (int i = 1; i <= 3; i++) do_push(DATA_W'(i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        for (int i = 0; i < 3; i++) do_pop();

        // Mode change while non-empty is deferred until drained.
        mode_in = 1'b0;
        do_idle();
        do_push(4'd1);
        do_push(4'd2);
        mode_in = 1'b1;
        do_pop();
        do_pop();
        do_idle();
        do_idle();

        // Reset mid-fill with a push on the reset edge.
        mode_in = 1'b0;
        do_idle();
        for (int i = 1; i <= 4; i++) do_push(DATA_W'(i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
        do_pop();

        // Empty buffer with push+pop together: push taken, pop rejected.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        do_pop();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic r, ps, pp;
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) mode_in = ~mode_in;
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 50);
            step(r, mode_in, ps, pp, DATA_W'($urandom));
        end

        do_idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pending_predictions", 32'(exp_q.size()), 32'd0);
        chk("pending_pops",        32'(pop_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
